// File: rtl/mplier32_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential radix-8 Booth multiplier.
interface mplier32_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 op_signed;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     mcand;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic [CNT_W-1:0]     group_idx;

  modport master (
    output in_valid, op_signed, mplier, mcand, out_ready,
    input  in_ready, out_valid, product, busy, group_idx
  );

  modport slave (
    input  in_valid, op_signed, mplier, mcand, out_ready,
    output in_ready, out_valid, product, busy, group_idx
  );
endinterface

// File: rtl/mplier32_seq_ctrl.sv
// Sequential radix-8 Booth multiplier: one recoded group per cycle, MSB-first,
// accumulating into a 2*WIDTH register; exact product on a valid/ready output.
module mplier32_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  mplier32_seq_ctrl_if.slave  io
);
  localparam int GROUPS = (WIDTH + 3) / 3;
  localparam int EW     = WIDTH + 3;
  localparam int PW     = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [EW-1:0]    mcand_q, mplier_q;
  logic [PW-1:0]    acc_q, product_q;
  logic             out_valid_q, busy_q;
  logic [CNT_W-1:0] grp_q;

  logic             m_ext, c_ext;
  logic [3:0]       grp_bits;
  logic             neg;
  logic [2:0]       mag;
  logic [PW-1:0]    mc_w, pp_mag, pp, acc_d;

  assign m_ext = io.op_signed & io.mplier[WIDTH-1];
  assign c_ext = io.op_signed & io.mcand[WIDTH-1];

  // Recode the current overlapping 4-bit window into sign + magnitude 0..4.
  always_comb begin
    grp_bits = 4'(mplier_q >> (3 * grp_q));
    neg      = grp_bits[3];
    mag      = 3'd0;
    case (grp_bits)
      4'd0, 4'd15:  mag = 3'd0;
      4'd1, 4'd2:   mag = 3'd1;
      4'd3, 4'd4:   mag = 3'd2;
      4'd5, 4'd6:   mag = 3'd3;
      4'd7:         mag = 3'd4;
      4'd8:         mag = 3'd4;
      4'd9, 4'd10:  mag = 3'd3;
      4'd11, 4'd12: mag = 3'd2;
      4'd13, 4'd14: mag = 3'd1;
      default:      mag = 3'd0;
    endcase
    mc_w = {{(PW-EW){mcand_q[EW-1]}}, mcand_q};
    case (mag)
      3'd0:    pp_mag = '0;
      3'd1:    pp_mag = mc_w;
      3'd2:    pp_mag = mc_w << 1;
      3'd3:    pp_mag = (mc_w << 1) + mc_w;
      default: pp_mag = mc_w << 2;
    endcase
    pp    = neg ? -pp_mag : pp_mag;
    acc_d = (acc_q << 3) + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      grp_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            mcand_q  <= {{3{c_ext}}, io.mcand};
            mplier_q <= {m_ext, m_ext, io.mplier, 1'b0};
            acc_q    <= '0;
            grp_q    <= CNT_W'(GROUPS - 1);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (grp_q == '0) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            grp_q <= grp_q - 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held low through reset so nothing is accepted while the block is clearing.
  assign io.in_ready  = (state_q == IDLE) & ~rst;
  assign io.out_valid = out_valid_q;
  assign io.product   = product_q;
  assign io.busy      = busy_q;
  assign io.group_idx = grp_q;
endmodule

// File: tb/tb_mplier32_seq_ctrl.sv
// Scoreboard bench for the sequential Booth multiplier: golden products are
// queued at accept and compared when the product handshake completes.
module tb_mplier32_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mplier32_seq_ctrl_if #(.WIDTH(32), .CNT_W(4)) bus ();
  mplier32_seq_ctrl #(.WIDTH(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .io(bus.slave));

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  bit   [15:0] cov = '0;

  function automatic logic [63:0] golden(bit s, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit s, input logic [31:0] a, input logic [31:0] b);
    bit          acc;
    int          n;
    logic [34:0] ext;
    n = 0;
    bus.in_valid = 1'b1; bus.op_signed = s; bus.mplier = a; bus.mcand = b;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: in_ready=0 for %0d cycles, required 1", n);
    end else begin
      exp_q.push_back(golden(s, a, b));
      ext = {s & a[31], s & a[31], a, 1'b0};
      for (int i = 0; i < 11; i++) cov[ext[3*i +: 4]] = 1'b1;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL wait_out: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: in_ready/out_valid/busy=%b, required 000",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    checks++;
    if (bus.product !== 64'h0 || bus.group_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: product=%h group_idx=%0d, required 0 and 0",
               bus.product, bus.group_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int          lat;
    logic [63:0] e;
    send(1'b0, 32'd3, 32'd5);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.group_idx !== 4'(11 - lat)) begin
        errors++;
        $display("FAIL basic_run: cycle %0d busy=%b group_idx=%0d, required 1 and %0d",
                 lat, bus.busy, bus.group_idx, 11 - lat);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles, required 12", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.product !== 64'd15 || bus.product !== e || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_product: product=%h busy=%b, required %h and 1", bus.product, bus.busy, e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== 64'd15) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b busy=%b product=%h, required 0 1 0 15",
               bus.out_valid, bus.in_ready, bus.busy, bus.product);
    end
  endtask

  task automatic test_corners();
    bit          ts[5];
    logic [31:0] ta[5];
    logic [31:0] tb[5];
    logic [63:0] te[5];
    int          lat;
    ts = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
    tb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    te = '{64'h1, 64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
           64'hC000_0000_8000_0000, 64'h0};
    for (int i = 0; i < 5; i++) begin
      send(ts[i], ta[i], tb[i]);
      wait_out(lat);
      void'(exp_q.pop_front());
      checks++;
      if (bus.product !== te[i]) begin
        errors++;
        $display("FAIL corner_%0d: product=%h, required %h", i, bus.product, te[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] e;
    send(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out(lat);
    e = exp_q.pop_front();
    bus.in_valid = 1'b1; bus.mplier = 32'd2; bus.mcand = 32'd2;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.product !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: product=%h out_valid=%b in_ready=%b, required %h 1 0",
                 i, bus.product, bus.out_valid, bus.in_ready, e);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== e) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b product=%h, required 1 0 %h",
               bus.in_ready, bus.out_valid, bus.product, e);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    int n;
    send(1'b1, -32'sd1000, 32'd1234);
    n = 0;
    while (bus.group_idx !== 4'd5 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.group_idx !== 4'd5) begin
      errors++;
      $display("FAIL mid_reach: group_idx=%0d, required 5", bus.group_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.product !== 64'h0 || bus.busy !== 1'b0 ||
        bus.group_idx !== 4'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b product=%h busy=%b group_idx=%0d in_ready=%b, required 0 0 0 0 1",
               bus.out_valid, bus.product, bus.busy, bus.group_idx, bus.in_ready);
    end
    exp_q.delete();
    send(1'b0, 32'd7, 32'd9);
    wait_out(lat);
    void'(exp_q.pop_front());
    checks++;
    if (bus.product !== 64'd63) begin
      errors++;
      $display("FAIL mid_after: product=%h, required 63", bus.product);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 1500;
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
          send(1'($urandom_range(0, 1)), rand_op(), rand_op());
        end
      end
      begin
        int          cyc;
        bit          take;
        logic [63:0] prod, e;
        cyc = 0;
        while (got < N && cyc < N * 40) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          take = bus.out_valid & bus.out_ready;
          prod = bus.product;
          tick();
          cyc++;
          if (take) begin
            e = exp_q.pop_front();
            checks++;
            if (prod !== e) begin
              errors++;
              $display("FAIL rand_%0d: product=%h, required %h", got, prod, e);
            end
            got++;
          end
        end
        bus.out_ready = 1'b0;
      end
    join
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL rand_count: %0d products, required %0d", got, N);
    end
    checks++;
    if (cov !== 16'hFFFF) begin
      errors++;
      $display("FAIL digit_cover: groups seen=%h, required ffff", cov);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op_signed = 1'b0;
    bus.mplier = '0; bus.mcand = '0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
